// File: rtl/exe_wb_pipe_pkg.sv
// Shared definitions for the execute/writeback slice of the 3-stage RV32I core:
// opcodes, the canonical NOP, the writeback source encoding and the load-stall states.
package pipe_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/exe_wb_pipe_load_stall_fsm.sv
// Load-stall controller: keeps a load in writeback for LOAD_WAIT_CYCLES extra
// cycles, stalls the front end meanwhile and masks the register-write enable.
module load_stall_fsm
  import pipe_pkg::*;
#(
  parameter int LOAD_WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rd_en,
  input  logic i_reg_wr_q,
  output logic o_stall,
  output logic o_reg_wr
);

  // The wait counter is 2 bits wide, so at most 3 extra load cycles are supported.
  localparam logic [1:0] WAIT_INIT = 2'(LOAD_WAIT_CYCLES);

  state_e     r_state;
  state_e     w_next_state;
  logic [1:0] r_cnt;
  logic [1:0] w_next_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      RUN: begin
        if (i_rd_en && (LOAD_WAIT_CYCLES > 0)) begin
          w_next_state = LOAD_WAIT;
          w_next_cnt   = WAIT_INIT;
        end
      end
      LOAD_WAIT: begin
        w_next_cnt = r_cnt - 2'd1;
        if (r_cnt == 2'd1) begin
          w_next_state = RUN;
        end
      end
      default: begin
        w_next_state = RUN;
        w_next_cnt   = 2'd0;
      end
    endcase
  end

  assign o_stall  = (r_state == LOAD_WAIT);
  assign o_reg_wr = i_reg_wr_q && (r_state == RUN);

endmodule

// File: rtl/exe_wb_pipe.sv
// Execute-to-writeback pipeline register with load stall and branch flush control.
// Define EXE_WB_PERF_CNT_EN to add the stall_count/flush_count performance counters.
module exe_wb_pipe
  import pipe_pkg::*;
#(
  parameter int LOAD_WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction_execute,
  input  logic [31:0] pc_execute,
  input  logic [31:0] alu_result_execute,
  input  logic [31:0] rdata2_execute,
  input  logic        reg_wr_execute,
  input  logic        rd_en_execute,
  input  logic        wr_en_execute,
  input  logic [1:0]  wb_sel_execute,
  input  logic        br_taken,
  output logic [31:0] instruction_wback,
  output logic [31:0] pc_wback,
  output logic [31:0] alu_result_wback,
  output logic [31:0] rdata2_wback,
  output logic        reg_wr_wback,
  output logic        rd_en_wback,
  output logic        wr_en_wback,
  output logic [1:0]  wb_sel_wback,
  output logic        stall_front,
  output logic        flush_front
`ifdef EXE_WB_PERF_CNT_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  logic [31:0] r_instruction;
  logic [31:0] r_pc;
  logic [31:0] r_alu_result;
  logic [31:0] r_rdata2;
  logic        r_reg_wr;
  logic        r_rd_en;
  logic        r_wr_en;
  logic [1:0]  r_wb_sel;
  logic        w_stall;
  logic        w_reg_wr;

  load_stall_fsm #(
    .LOAD_WAIT_CYCLES(LOAD_WAIT_CYCLES)
  ) u_load_stall_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rd_en   (rd_en_execute),
    .i_reg_wr_q(r_reg_wr),
    .o_stall   (w_stall),
    .o_reg_wr  (w_reg_wr)
  );

  // While a load waits the registers hold; the store enable is dropped so it
  // can only ever be seen on the first writeback cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instruction <= NOP_INSN;
      r_pc          <= 32'd0;
      r_alu_result  <= 32'd0;
      r_rdata2      <= 32'd0;
      r_reg_wr      <= 1'b0;
      r_rd_en       <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wb_sel      <= 2'd0;
    end else if (!w_stall) begin
      r_instruction <= instruction_execute;
      r_pc          <= pc_execute;
      r_alu_result  <= alu_result_execute;
      r_rdata2      <= rdata2_execute;
      r_reg_wr      <= reg_wr_execute;
      r_rd_en       <= rd_en_execute;
      r_wr_en       <= wr_en_execute;
      r_wb_sel      <= wb_sel_execute;
    end else begin
      r_wr_en       <= 1'b0;
    end
  end

  assign instruction_wback = r_instruction;
  assign pc_wback          = r_pc;
  assign alu_result_wback  = r_alu_result;
  assign rdata2_wback      = r_rdata2;
  assign reg_wr_wback      = w_reg_wr;
  assign rd_en_wback       = r_rd_en;
  assign wr_en_wback       = r_wr_en;
  assign wb_sel_wback      = r_wb_sel;
  assign stall_front       = w_stall;
  // Gated by reset so no redirect leaks out while the core is held in reset.
  assign flush_front       = br_taken && !w_stall && rst_n;

`ifdef EXE_WB_PERF_CNT_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      if (stall_front) r_stall_count <= r_stall_count + 32'd1;
      if (flush_front) r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`endif

endmodule
